// File: rtl/virtual_ds2431_mem_cmd_sched_if.sv
// Bus bundle for the DS2431 memory-command scheduler: upstream command control,
// the shared byte-transfer port, and the per-sub-function trigger/mux lanes.
interface virtual_ds2431_mem_cmd_sched_if;
  // Transfer handshake: a requester raises transTrig for one cycle (direction in
  // nRxTx, byte in sentDat); the byte engine drops ByteTransDone while busy and
  // its rising edge marks completion, with receiveDat valid on that edge.
  logic        cmdStart;
  logic        endCmd;
  logic [7:0]  receiveDat;
  logic        ByteTransDone;
  logic        transTrig;
  logic        nRxTx;
  logic [7:0]  sentDat;
  logic [7:0]  TA1;
  logic [7:0]  TA2;
  logic [3:0]  subTrig;
  logic [3:0]  subTransTrig;
  logic [3:0]  subNRxTx;
  logic [31:0] subSentDat;
  logic [3:0]  subDone;
  logic [3:0]  subFailed;
  logic        subEndCmd;
  logic [2:0]  activeCmd;
  logic        memCmdDone;
  logic        memCmdFailed;

  modport master (
    input  cmdStart, endCmd, receiveDat, ByteTransDone,
    input  subTransTrig, subNRxTx, subSentDat, subDone, subFailed,
    output transTrig, nRxTx, sentDat, TA1, TA2, subTrig, subEndCmd,
    output activeCmd, memCmdDone, memCmdFailed
  );

  modport slave (
    output cmdStart, endCmd, receiveDat, ByteTransDone,
    output subTransTrig, subNRxTx, subSentDat, subDone, subFailed,
    input  transTrig, nRxTx, sentDat, TA1, TA2, subTrig, subEndCmd,
    input  activeCmd, memCmdDone, memCmdFailed
  );
endinterface

// File: rtl/virtual_ds2431_mem_cmd_sched.sv
// Memory-function-layer scheduler for the virtual DS2431: receives command/TA bytes,
// launches the sub-function and muxes the byte port. Optional watchdog: MEM_CMD_WDT_EN.
module virtual_ds2431_mem_cmd_sched #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic                                clk,
  input  logic                                nRst,
  virtual_ds2431_mem_cmd_sched_if.master      bus,
  output logic [2:0]                          dbg_state_o
);

  // Encoding is visible on dbg_state_o: 0 IDLE .. 5 RUN.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RX_CMD = 3'd1,
    S_RX_TA1 = 3'd2,
    S_RX_TA2 = 3'd3,
    S_LAUNCH = 3'd4,
    S_RUN    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        rx_trig_q, rx_trig_d;
  logic        btd_q;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  ta1_q, ta1_d;
  logic [7:0]  ta2_q, ta2_d;
  logic [2:0]  active_q, active_d;
  logic        done_q, done_d;
  logic        failed_q, failed_d;

  logic        btd_rise;
  logic        is_rx;
  logic        is_run;
  logic        sub_done;
  logic        sub_failed;
  logic        wdt_take;

  assign btd_rise   = bus.ByteTransDone & ~btd_q;
  assign is_rx      = (state_q == S_RX_CMD) || (state_q == S_RX_TA1) || (state_q == S_RX_TA2);
  assign is_run     = (state_q == S_RUN);
  assign sub_done   = bus.subDone[idx_q];
  assign sub_failed = bus.subFailed[idx_q];

`ifdef MEM_CMD_WDT_EN
  logic [CNT_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic             btd_edge;
  logic             wdt_fire;

  assign btd_edge = bus.ByteTransDone ^ btd_q;
  assign wdt_fire = (state_q != S_IDLE) && (wdt_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  // A sub-function that finishes on the expiry cycle wins over the watchdog.
  assign wdt_take = wdt_fire && !(is_run && (sub_done || sub_failed));

  always_comb begin
    wdt_cnt_d = wdt_cnt_q + CNT_W'(1);
    if ((state_q == S_IDLE) || bus.transTrig || btd_edge) begin
      wdt_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      wdt_cnt_q <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
    end
  end
`else
  logic unused_wdt_cfg;

  assign unused_wdt_cfg = ^(CNT_W'(TIMEOUT_CYC));
  assign wdt_take       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rx_trig_d = 1'b0;
    idx_d     = idx_q;
    ta1_d     = ta1_q;
    ta2_d     = ta2_q;
    active_d  = active_q;
    done_d    = 1'b0;
    failed_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmdStart) begin
          state_d   = S_RX_CMD;
          rx_trig_d = 1'b1;
        end
      end
      S_RX_CMD: begin
        if (btd_rise) begin
          case (bus.receiveDat)
            8'h0F: begin
              idx_d     = 2'd0;
              state_d   = S_RX_TA1;
              rx_trig_d = 1'b1;
            end
            8'hAA: begin
              idx_d   = 2'd1;
              state_d = S_LAUNCH;
            end
            8'h55: begin
              idx_d     = 2'd2;
              state_d   = S_RX_TA1;
              rx_trig_d = 1'b1;
            end
            8'hF0: begin
              idx_d     = 2'd3;
              state_d   = S_RX_TA1;
              rx_trig_d = 1'b1;
            end
            default: begin
              failed_d = 1'b1;
              state_d  = S_IDLE;
            end
          endcase
        end
      end
      S_RX_TA1: begin
        if (btd_rise) begin
          ta1_d     = bus.receiveDat;
          state_d   = S_RX_TA2;
          rx_trig_d = 1'b1;
        end
      end
      S_RX_TA2: begin
        if (btd_rise) begin
          ta2_d   = bus.receiveDat;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        active_d = 3'(idx_q) + 3'd1;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (sub_failed) begin
          failed_d = 1'b1;
          active_d = 3'd0;
          state_d  = S_IDLE;
        end else if (sub_done) begin
          done_d   = 1'b1;
          active_d = 3'd0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        active_d = 3'd0;
      end
    endcase

    if (wdt_take) begin
      state_d   = S_IDLE;
      rx_trig_d = 1'b0;
      active_d  = 3'd0;
      done_d    = 1'b0;
      failed_d  = 1'b1;
    end

    // Bus reset overrides everything, silently; latched address bytes survive.
    if (bus.endCmd) begin
      state_d   = S_IDLE;
      rx_trig_d = 1'b0;
      active_d  = 3'd0;
      done_d    = 1'b0;
      failed_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q   <= S_IDLE;
      rx_trig_q <= 1'b0;
      btd_q     <= 1'b1;
      idx_q     <= 2'd0;
      ta1_q     <= 8'h00;
      ta2_q     <= 8'h00;
      active_q  <= 3'd0;
      done_q    <= 1'b0;
      failed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_trig_q <= rx_trig_d;
      btd_q     <= bus.ByteTransDone;
      idx_q     <= idx_d;
      ta1_q     <= ta1_d;
      ta2_q     <= ta2_d;
      active_q  <= active_d;
      done_q    <= done_d;
      failed_q  <= failed_d;
    end
  end

  // Byte port: own receive requests in RX states, zero-latency pass-through in RUN.
  always_comb begin
    bus.transTrig = 1'b0;
    bus.nRxTx     = 1'b0;
    bus.sentDat   = 8'hFF;
    if (is_rx) begin
      bus.transTrig = rx_trig_q;
    end else if (is_run) begin
      bus.transTrig = bus.subTransTrig[idx_q];
      bus.nRxTx     = bus.subNRxTx[idx_q];
      bus.sentDat   = bus.subSentDat[8*idx_q +: 8];
    end
  end

  assign bus.subTrig      = (state_q == S_LAUNCH) ? (4'b0001 << idx_q) : 4'b0000;
  assign bus.subEndCmd    = bus.endCmd | wdt_take;
  assign bus.TA1          = ta1_q;
  assign bus.TA2          = ta2_q;
  assign bus.activeCmd    = active_q;
  assign bus.memCmdDone   = done_q;
  assign bus.memCmdFailed = failed_q;
  assign dbg_state_o      = state_q;

endmodule
